// File: rtl/sram_1rw_ctrl_if.sv
// rtl/sram_1rw_ctrl_if.sv - request/response stream bundle between fabric and sram_1rw_ctrl
//
// Request stream (master -> slave): req_valid, req_we, req_addr, req_wdata; req_ready back.
// Response stream (slave -> master): rsp_valid, rsp_rdata; rsp_ready back.
// master = fabric side, slave = controller side.
interface sram_1rw_ctrl_if #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_1rw_ctrl.sv
// rtl/sram_1rw_ctrl.sv - host-side initiator for a single-port OpenRAM 1rw macro
//
// Ports:
//   clk0, rstb0      clock shared with the macro; asynchronous active-low reset
//   bus (slave)      request stream in, read-response stream out
//   init_busy        memory clear in progress (0 when SRAM_CTRL_INIT_EN is undefined)
//   csb0/web0/addr0/din0  registered macro controls, dout0 macro read data
//
// Optional macro SRAM_CTRL_INIT_EN: after reset, clear every word to 0 before
// accepting requests.
module sram_1rw_ctrl #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    sram_1rw_ctrl_if.slave        bus,
    output logic                  init_busy,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CRD_W = PTR_W + 2;

    logic                  in_init;
    logic [ADDR_WIDTH-1:0] init_addr;

    logic                  accept;
    logic                  s1;
    logic                  s2;
    logic                  push;
    logic                  pop;
    logic [CRD_W-1:0]      credits;

    logic [DATA_WIDTH-1:0] buf_mem [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  csb_n;
    logic                  web_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] din_n;

`ifdef SRAM_CTRL_INIT_EN
    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [ADDR_WIDTH-1:0] init_cnt_n;

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_n;
            init_cnt <= init_cnt_n;
        end
    end

    // One clear write per cycle; leave INIT once the last address has been issued.
    always_comb begin
        state_n    = state;
        init_cnt_n = init_cnt;
        if (state == ST_INIT) begin
            init_cnt_n = init_cnt + 1'b1;
            if (init_cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                state_n = ST_RUN;
            end
        end
    end

    assign in_init   = (state == ST_INIT);
    assign init_addr = init_cnt;
`else
    assign in_init   = 1'b0;
    assign init_addr = '0;
`endif

    assign init_busy = in_init;

    // Every in-flight read already owns a buffer slot, so the buffer can never
    // overflow. A pop in the same cycle is deliberately not credited.
    assign credits       = CRD_W'(s1) + CRD_W'(s2) + CRD_W'(count);
    assign bus.req_ready = !in_init && (credits < CRD_W'(RSP_DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.rsp_valid = (count != '0);
    assign bus.rsp_rdata = bus.rsp_valid ? buf_mem[rd_ptr] : '0;

    // s2 marks a read the macro sampled last edge; dout0 is valid now and
    // must be taken at this edge before it decays.
    assign push = s2;
    assign pop  = bus.rsp_valid && bus.rsp_ready;

    always_comb begin
        csb_n  = 1'b1;
        web_n  = 1'b1;
        addr_n = addr0;
        din_n  = din0;
        if (in_init) begin
            csb_n  = 1'b0;
            web_n  = 1'b0;
            addr_n = init_addr;
            din_n  = '0;
        end else if (accept) begin
            csb_n  = 1'b0;
            web_n  = !bus.req_we;
            addr_n = bus.req_addr;
            din_n  = bus.req_wdata;
        end
    end

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            csb0  <= 1'b1;
            web0  <= 1'b1;
            addr0 <= '0;
            din0  <= '0;
        end else begin
            csb0  <= csb_n;
            web0  <= web_n;
            addr0 <= addr_n;
            din0  <= din_n;
        end
    end

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= accept && !bus.req_we;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk0) begin
        if (push) begin
            buf_mem[wr_ptr] <= dout0;
        end
    end
endmodule
